// File: rtl/fb_reader.sv
// Frame fetcher: pipelined, credit-limited byte reads from the framebuffer, streamed out in raster order.
// Optional `FB_READER_DBLBUF_EN adds buf_sel to pick FB_BASE1 per frame.
module fb_reader_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic [W-1:0]                 push_dat_i,
  input  logic                         pop_i,
  output logic                         vld_o,
  output logic [W-1:0]                 dat_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_dat_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign vld_o   = (count_q != '0);
  // Head is gated so the data output reads 0 whenever nothing is held.
  assign dat_o   = vld_o ? mem_q[rd_ptr_q] : '0;
  assign count_o = count_q;
endmodule

module fb_reader #(
  parameter logic [31:0] FB_BASE    = 32'h0000_0000,
  parameter logic [31:0] FB_BASE1   = 32'h0004_B000,
  parameter int          H_RES      = 640,
  parameter int          V_RES      = 480,
  parameter int          FIFO_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        frame_done,
  output logic [31:0] read_address,
  output logic        read_enable,
  input  logic        wait_request,
  input  logic [7:0]  read_data,
  input  logic        read_data_valid,
  output logic [7:0]  pix_data,
  output logic        pix_valid,
  input  logic        pix_ready,
  output logic        pix_sof
`ifdef FB_READER_DBLBUF_EN
  ,
  input  logic        buf_sel
`endif
);
  localparam int NPIX = H_RES * V_RES;
  localparam int IW   = $clog2(NPIX + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(NPIX - 1);
  localparam logic [IW-1:0] NPIX_W   = IW'(NPIX);
  localparam logic [CW:0]   DEPTH_W  = (CW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t        state_q;
  logic [31:0]   base_q, addr_q;
  logic [IW-1:0] issue_idx_q, cons_q;
  logic [CW-1:0] out_q;
  logic          busy_q, done_q, re_q;

  logic [31:0]   base_d;
  logic [IW-1:0] issue_idx_d;
  logic [CW-1:0] out_d, cnt_d, fifo_cnt;
  logic          accept, ret, pop, credit_ok, last_acc;

`ifdef FB_READER_DBLBUF_EN
  assign base_d = buf_sel ? FB_BASE1 : FB_BASE;
`else
  logic unused_base1;
  assign unused_base1 = ^FB_BASE1;
  assign base_d       = FB_BASE;
`endif

  assign accept      = re_q & ~wait_request;
  // Returns with nothing outstanding are leftovers from before a reset.
  assign ret         = read_data_valid & (out_q != '0);
  assign pop         = pix_valid & pix_ready;
  assign out_d       = out_q + CW'(accept) - CW'(ret);
  assign cnt_d       = fifo_cnt + CW'(ret) - CW'(pop);
  // Next-cycle occupancy counts every accepted read as an already-reserved FIFO slot.
  assign credit_ok   = ({1'b0, out_d} + {1'b0, cnt_d}) < DEPTH_W;
  assign issue_idx_d = issue_idx_q + IW'(accept);
  assign last_acc    = accept && (issue_idx_q == LAST_IDX);

  fb_reader_fifo #(.W(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (ret),
    .push_dat_i (read_data),
    .pop_i      (pop),
    .vld_o      (pix_valid),
    .dat_o      (pix_data),
    .count_o    (fifo_cnt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      base_q      <= '0;
      addr_q      <= '0;
      issue_idx_q <= '0;
      cons_q      <= '0;
      out_q       <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      re_q        <= 1'b0;
    end else begin
      out_q  <= out_d;
      done_q <= 1'b0;
      if (pop) cons_q <= cons_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            base_q      <= base_d;
            issue_idx_q <= '0;
            cons_q      <= '0;
            busy_q      <= 1'b1;
            re_q        <= 1'b1;
            addr_q      <= base_d;
            state_q     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          issue_idx_q <= issue_idx_d;
          if (last_acc) begin
            re_q    <= 1'b0;
            state_q <= S_DRAIN;
          end else if (!(re_q && wait_request)) begin
            re_q   <= credit_ok;
            addr_q <= base_q + 32'(issue_idx_d);
          end
        end
        S_DRAIN: begin
          if (out_q == '0 && fifo_cnt == '0 && cons_q == NPIX_W) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy         = busy_q;
  assign frame_done   = done_q;
  assign read_enable  = re_q;
  assign read_address = addr_q;
  assign pix_sof      = pix_valid & (cons_q == '0);
endmodule

// File: tb/tb_fb_reader.sv
// Bench for fb_reader: small 4x2 frame, 2-cycle memory model, scoreboard on reads and pixels.
`timescale 1ns/1ps
module tb_fb_reader;
  localparam int H = 4, V = 2, DEPTH = 4, NPIX = H * V;

  logic        clk = 1'b0;
  logic        rst, start, wait_request, read_data_valid, pix_ready;
  logic        busy, frame_done, read_enable, pix_valid, pix_sof;
  logic [31:0] read_address;
  logic [7:0]  read_data, pix_data;
`ifdef FB_READER_DBLBUF_EN
  logic        buf_sel;
`endif

  fb_reader #(.FB_BASE(32'h0), .FB_BASE1(32'h100), .H_RES(H), .V_RES(V), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .frame_done(frame_done),
    .read_address(read_address), .read_enable(read_enable), .wait_request(wait_request),
    .read_data(read_data), .read_data_valid(read_data_valid),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_sof(pix_sof)
`ifdef FB_READER_DBLBUF_EN
    , .buf_sel(buf_sel)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;
  logic [31:0] exp_addr [$];
  logic [8:0]  exp_pix [$];
  int rd_cnt, done_cnt, stall_left, stall_seen, inj_stale;
  logic [31:0] stall_addr;
  logic        prev_wr;
  logic [31:0] prev_addr;
  logic        p0v, p1v;
  logic [7:0]  p0d, p1d;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Memory slave, stall injector and scoreboard monitor, all evaluated mid-cycle.
  initial begin
    wait_request = 0; read_data_valid = 0; read_data = 0;
    p0v = 0; p1v = 0; p0d = 0; p1d = 0; prev_wr = 0; prev_addr = 0;
    forever begin
      @(negedge clk);
      if (prev_wr) begin
        check("stall_hold_re", 32'(read_enable), 32'd1);
        check("stall_hold_addr", read_address, prev_addr);
      end
      wait_request = 0;
      if (read_enable && read_address == stall_addr && stall_left > 0) begin
        wait_request = 1;
        stall_left--;
        stall_seen++;
      end
      prev_wr   = wait_request;
      prev_addr = read_address;
      if (read_enable && !wait_request) begin
        rd_cnt++;
        if (exp_addr.size() == 0) check("extra_read", read_address, 32'hDEAD_BEEF);
        else check("rd_addr", read_address, exp_addr.pop_front());
      end
      read_data_valid = p1v;
      read_data       = p1d;
      if (inj_stale > 0) begin
        read_data_valid = 1;
        read_data       = 8'hEE;
        inj_stale--;
      end
      p1v = p0v; p1d = p0d;
      p0v = read_enable && !wait_request;
      p0d = read_address[7:0] + 8'h10;
      if (pix_valid && pix_ready) begin
        if (exp_pix.size() == 0) check("extra_pixel", {23'd0, pix_sof, pix_data}, 32'h1FF);
        else check("pixel{sof,data}", {23'd0, pix_sof, pix_data}, {23'd0, exp_pix.pop_front()});
      end
      if (frame_done) done_cnt++;
    end
  end

  task automatic run_frame(input logic [31:0] base, input int st, input int hold,
                           input bit restart, input int exp_reads, input int exp_done);
    int cyc;
    logic [31:0] a;
    for (int i = 0; i < NPIX; i++) begin
      a = base + 32'(i);
      exp_addr.push_back(a);
      exp_pix.push_back({(i == 0), a[7:0] + 8'h10});
    end
    stall_addr = (st >= 0) ? 32'(st) : 32'hFFFF_FFFF;
    stall_left = (st >= 0) ? 3 : 0;
    stall_seen = 0; rd_cnt = 0; done_cnt = 0;
    pix_ready  = (hold == 0);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    check("busy_after_start", 32'(busy), 32'd1);
    check("first_re", 32'(read_enable), 32'd1);
    check("first_addr", read_address, base);
    cyc = 0;
    while (done_cnt == 0 && cyc < 400) begin
      if (hold > 0 && cyc == hold) begin
        check("hold_reads", 32'(rd_cnt), 32'(DEPTH));
        check("hold_fifo_valid", 32'(pix_valid), 32'd1);
        check("hold_sof", 32'(pix_sof), 32'd1);
        pix_ready = 1;
      end
      start = (restart && cyc == 5);
`ifdef FB_READER_DBLBUF_EN
      if (cyc == 3) buf_sel = ~buf_sel;
`endif
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    if (done_cnt == 0) check("frame_done_timeout", 32'(done_cnt), 32'd1);
    repeat (3) @(posedge clk);
    #1;
    check("done_pulses", 32'(done_cnt), 32'(exp_done));
    check("busy_after_done", 32'(busy), 32'd0);
    check("reads_issued", 32'(rd_cnt), 32'(exp_reads));
    check("pixels_left", 32'(exp_pix.size()), 32'd0);
    if (st >= 0) check("stall_cycles", 32'(stall_seen), 32'd3);
  endtask

  typedef struct {
    int stall_a;
    int hold;
    bit restart;
    int exp_reads;
    int exp_done;
  } vec_t;

  initial begin
    vec_t vecs [4];
    vecs[0] = '{stall_a: -1, hold: 0,  restart: 0, exp_reads: NPIX, exp_done: 1};
    vecs[1] = '{stall_a: 2,  hold: 0,  restart: 0, exp_reads: NPIX, exp_done: 1};
    vecs[2] = '{stall_a: -1, hold: 20, restart: 0, exp_reads: NPIX, exp_done: 1};
    vecs[3] = '{stall_a: -1, hold: 0,  restart: 1, exp_reads: NPIX, exp_done: 1};
    rst = 1; start = 0; pix_ready = 1; inj_stale = 0;
    rd_cnt = 0; done_cnt = 0; stall_left = 0; stall_seen = 0; stall_addr = 32'hFFFF_FFFF;
`ifdef FB_READER_DBLBUF_EN
    buf_sel = 0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_re", 32'(read_enable), 32'd0);
    check("rst_addr", read_address, 32'd0);
    check("rst_pvalid", 32'(pix_valid), 32'd0);
    check("rst_pdata", 32'(pix_data), 32'd0);
    check("rst_sof", 32'(pix_sof), 32'd0);
    rst = 0;
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) begin
`ifdef FB_READER_DBLBUF_EN
      buf_sel = 0;
`endif
      run_frame(32'h0, vecs[i].stall_a, vecs[i].hold, vecs[i].restart,
                vecs[i].exp_reads, vecs[i].exp_done);
    end

    // Abort mid-frame after three accepted reads.
    for (int i = 0; i < NPIX; i++) exp_addr.push_back(32'(i));
    rd_cnt = 0;
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int c = 0; c < 50 && rd_cnt < 3; c++) begin
      @(posedge clk); #1;
    end
    check("pre_rst_reads", 32'(rd_cnt), 32'd3);
    rst = 1;
    exp_addr.delete();
    exp_pix.delete();
    @(posedge clk); #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_re", 32'(read_enable), 32'd0);
    check("abort_addr", read_address, 32'd0);
    check("abort_pvalid", 32'(pix_valid), 32'd0);
    check("abort_sof", 32'(pix_sof), 32'd0);
    done_cnt = 0;
    rst = 0;
    inj_stale = 2;
    repeat (5) @(posedge clk);
    #1;
    check("stale_dropped", 32'(pix_valid), 32'd0);
    check("abort_no_done", 32'(done_cnt), 32'd0);
`ifdef FB_READER_DBLBUF_EN
    buf_sel = 0;
`endif
    run_frame(32'h0, -1, 0, 0, NPIX, 1);

`ifdef FB_READER_DBLBUF_EN
    buf_sel = 1;
    run_frame(32'h100, -1, 0, 0, NPIX, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
